// File: rtl/ysyx_220053_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_ifu_pkg
// Purpose : Shared types and constants for the instruction fetch unit.
//           Defines the fetch FSM state encoding, the default reset PC,
//           the instruction word substituted on faults, and the helper that
//           turns a PC into a doubleword-aligned fetch address.
// Revision: 1.0 - initial release
// ============================================================================
package ysyx_220053_ifu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // issuing a fetch request
        WAIT = 2'd1,   // request accepted, awaiting response
        HOLD = 2'd2,   // instruction presented to decode
        NPC  = 2'd3    // instruction consumed, awaiting next PC
    } ifu_state_e;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] FAULT_INST       = 32'h0000_0000;

    // Memory is addressed by doubleword; the word within is chosen by pc[2].
    function automatic logic [63:0] fetch_addr(input logic [63:0] pc_in);
        return {pc_in[63:3], 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_220053_ifu_if.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_ifu_if
// Purpose : Bundles the fetch unit's external channels:
//           - dnpc_valid/dnpc          : next PC from execute
//           - imem_req_*/imem_addr     : fetch request (valid/ready)
//           - imem_rsp_*               : fetch response (valid only)
//           - inst_*/pc/fetch_fault    : instruction to decode (valid/ready)
//           - spurious_rsp             : sticky protocol-error flag
//           Modport master = fetch unit, slave = surrounding system.
// Revision: 1.0 - initial release
// ============================================================================
interface ysyx_220053_ifu_if #(
    parameter int BUS_W = 64
);
    logic              dnpc_valid;
    logic [63:0]       dnpc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [63:0]       imem_addr;
    logic              imem_rsp_valid;
    logic [BUS_W-1:0]  imem_rsp_data;
    logic              imem_rsp_err;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [63:0]       pc;
    logic              fetch_fault;
    logic              spurious_rsp;

    modport master (
        input  dnpc_valid, dnpc,
        output imem_req_valid, imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, pc, fetch_fault, spurious_rsp,
        input  inst_ready
    );

    modport slave (
        output dnpc_valid, dnpc,
        input  imem_req_valid, imem_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, pc, fetch_fault, spurious_rsp,
        output inst_ready
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_220053_word_sel.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_word_sel
// Purpose : Combinational selection of the 32-bit instruction word out of a
//           BUS_W-wide memory response.
// Ports   : i_data [BUS_W] response data, i_sel upper/lower word (pc[2]),
//           o_word [32] selected word.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_220053_word_sel #(
    parameter int BUS_W = 64
) (
    input  wire logic [BUS_W-1:0] i_data,
    input  wire logic             i_sel,
    output logic      [31:0]      o_word
);

    generate
        if (BUS_W >= 64) begin : g_wide
            assign o_word = i_sel ? i_data[63:32] : i_data[31:0];
        end else begin : g_narrow
            // A single-word bus carries exactly one instruction.
            assign o_word = i_data[31:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ysyx_220053_ifu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_ifu
// Purpose : Instruction fetch unit. Owns the architectural PC, fetches the
//           instruction at PC from instruction memory, holds it until decode
//           accepts it, then waits for the next PC from execute.
// Ports   : clk, rst (sync, active-high)
//           bus (ysyx_220053_ifu_if.master): dnpc channel, imem request and
//           response channels, instruction output channel, spurious_rsp.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_220053_ifu
    import ysyx_220053_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          BUS_W    = 64
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ysyx_220053_ifu_if.master   bus
);

    ifu_state_e   r_state, w_state_next;
    logic [63:0]  r_pc, w_pc_next;
    logic [31:0]  r_inst, w_inst_next;
    logic         r_fault, w_fault_next;
    logic         r_spurious, w_spurious_next;
    logic [31:0]  w_word;
    logic         w_apply;

    ysyx_220053_word_sel #(
        .BUS_W (BUS_W)
    ) u_word_sel (
        .i_data (bus.imem_rsp_data),
        .i_sel  (r_pc[2]),
        .o_word (w_word)
    );

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_inst_next     = r_inst;
        w_fault_next    = r_fault;
        w_apply         = 1'b0;
        // Only WAIT expects a response; anything else is a protocol error.
        w_spurious_next = r_spurious | (bus.imem_rsp_valid && (r_state != WAIT));

        case (r_state)
            REQ: begin
                if (bus.imem_req_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_inst_next  = bus.imem_rsp_err ? FAULT_INST : w_word;
                    w_fault_next = bus.imem_rsp_err;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    if (bus.dnpc_valid) begin
                        w_apply = 1'b1;
                    end else begin
                        w_state_next = NPC;
                    end
                end
            end
            NPC: begin
                if (bus.dnpc_valid) begin
                    w_apply = 1'b1;
                end
            end
            default: w_state_next = REQ;
        endcase

        // A misaligned target never reaches memory: the fault is reported
        // directly as the next instruction.
        if (w_apply) begin
            w_pc_next = bus.dnpc;
            if (bus.dnpc[1]) begin
                w_inst_next  = FAULT_INST;
                w_fault_next = 1'b1;
                w_state_next = HOLD;
            end else begin
                w_state_next = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_inst     <= FAULT_INST;
            r_fault    <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_inst     <= w_inst_next;
            r_fault    <= w_fault_next;
            r_spurious <= w_spurious_next;
        end
    end

    // Request is suppressed while reset is held so memory never sees a
    // request it would drop.
    assign bus.imem_req_valid = (r_state == REQ) && !rst;
    assign bus.imem_addr      = fetch_addr(r_pc);
    assign bus.inst_valid     = (r_state == HOLD);
    assign bus.inst           = r_inst;
    assign bus.pc             = r_pc;
    assign bus.fetch_fault    = r_fault;
    assign bus.spurious_rsp   = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220053_ifu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_220053_ifu
// Purpose : Self-checking directed testbench for ysyx_220053_ifu. Expected
//           instructions are queued when the memory response is driven and
//           checked when decode accepts them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_220053_ifu;

    localparam logic [63:0] C_RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [63:0] exp_pc;
    int          t0;

    ysyx_220053_ifu_if #(.BUS_W(64)) bus ();

    ysyx_220053_ifu #(
        .RESET_PC (C_RESET_PC),
        .BUS_W    (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dnpc_valid     = 1'b0;
        bus.dnpc           = 64'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 64'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        chk("rst_req_valid",  bus.imem_req_valid, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_inst",       bus.inst, 0);
        chk("rst_fault",      bus.fetch_fault, 0);
        chk("rst_spurious",   bus.spurious_rsp, 0);
        chk("rst_pc",         bus.pc, C_RESET_PC);
        rst = 1'b0;
        #1;
        chk("post_rst_req_valid", bus.imem_req_valid, 1);
        sb.delete();
        exp_pc = C_RESET_PC;
    endtask

    // Expects the DUT in REQ; returns with the DUT in HOLD.
    task automatic fetch(input logic [63:0] data, input logic err, input int stall);
        logic [63:0] a;
        exp_t        e;
        a = {exp_pc[63:3], 3'b000};
        chk("req_valid", bus.imem_req_valid, 1);
        chk("req_addr",  bus.imem_addr, a);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_req_valid", bus.imem_req_valid, 1);
            chk("stall_addr",      bus.imem_addr, a);
        end
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        chk("wait_req_valid",  bus.imem_req_valid, 0);
        chk("wait_inst_valid", bus.inst_valid, 0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        e.inst  = err ? 32'h0 : (exp_pc[2] ? data[63:32] : data[31:0]);
        e.pc    = exp_pc;
        e.fault = err;
        sb.push_back(e);
        step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 64'h0;
        bus.imem_rsp_err   = 1'b0;
        chk("hold_inst_valid", bus.inst_valid, 1);
        chk("hold_req_valid",  bus.imem_req_valid, 0);
    endtask

    // Expects the DUT in HOLD; decode stalls `hold` cycles then accepts.
    task automatic consume(input int hold, input logic dv, input logic [63:0] d);
        exp_t e;
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("stall_inst_valid", bus.inst_valid, 1);
            chk("stall_inst",       bus.inst, e.inst);
            chk("stall_pc",         bus.pc, e.pc);
            chk("stall_fault",      bus.fetch_fault, e.fault);
            step();
        end
        chk("inst_valid", bus.inst_valid, 1);
        chk("inst",       bus.inst, e.inst);
        chk("inst_pc",    bus.pc, e.pc);
        chk("inst_fault", bus.fetch_fault, e.fault);
        bus.inst_ready = 1'b1;
        bus.dnpc_valid = dv;
        bus.dnpc       = d;
        step();
        bus.inst_ready = 1'b0;
        bus.dnpc_valid = 1'b0;
        if (dv) exp_pc = d;
    endtask

    // Expects the DUT in NPC.
    task automatic give_dnpc(input logic [63:0] d);
        chk("npc_inst_valid", bus.inst_valid, 0);
        chk("npc_req_valid",  bus.imem_req_valid, 0);
        bus.dnpc_valid = 1'b1;
        bus.dnpc       = d;
        step();
        bus.dnpc_valid = 1'b0;
        exp_pc = d;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        idle_inputs();
        exp_pc = C_RESET_PC;

        // Reset and first fetch: lower word at 8000_0000.
        do_reset();
        fetch(64'h00100093_00000013, 1'b0, 0);

        // Accept with next PC in the same cycle; upper word of same doubleword.
        consume(0, 1'b1, 64'h8000_0004);
        t0 = cyc - 1;  // cycle in which dnpc_valid was presented
        chk("dnpc_req_next_cycle", bus.imem_req_valid, 1);
        fetch(64'h00100093_00000013, 1'b0, 0);
        chk("dnpc_to_inst_latency", cyc - t0, 3);
        consume(0, 1'b1, 64'h8000_0008);

        // Memory back-pressure, then decode back-pressure.
        fetch(64'hdeadbeef_00a00513, 1'b0, 3);
        consume(5, 1'b1, 64'h8000_0006);

        // Misaligned target: fault reported without touching memory.
        chk("misalign_req_valid", bus.imem_req_valid, 0);
        e.inst = 32'h0; e.pc = 64'h8000_0006; e.fault = 1'b1;
        sb.push_back(e);
        consume(0, 1'b0, 64'h0);
        chk("misalign_npc_req_valid", bus.imem_req_valid, 0);

        // Access fault on the response.
        give_dnpc(64'h8000_0008);
        fetch(64'h12345678_9abcdef0, 1'b1, 0);
        consume(0, 1'b0, 64'h0);

        // Stray response while waiting for the next PC.
        chk("spur_before", bus.spurious_rsp, 0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 64'hffff_ffff_ffff_ffff;
        step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 64'h0;
        chk("spur_set",        bus.spurious_rsp, 1);
        chk("spur_inst_valid", bus.inst_valid, 0);
        chk("spur_inst",       bus.inst, 0);
        chk("spur_pc",         bus.pc, 64'h8000_0008);
        step();
        chk("spur_sticky", bus.spurious_rsp, 1);
        give_dnpc(64'h8000_0010);
        fetch(64'h00000000_00c58593, 1'b0, 0);
        chk("spur_sticky_after_fetch", bus.spurious_rsp, 1);
        consume(0, 1'b0, 64'h0);
        do_reset();

        // Reset while waiting for a response.
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        chk("pre_rst_wait_req_valid", bus.imem_req_valid, 0);
        do_reset();

        // Reset while holding an instruction.
        fetch(64'h00100093_00000013, 1'b0, 0);
        do_reset();

        // Normal operation resumes after reset.
        fetch(64'h00100093_00000013, 1'b0, 0);
        consume(0, 1'b0, 64'h0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
